// File: rtl/seq_detect_scheduler.sv
// seq_detect_scheduler: round-robin time-sharing of one external serial
// 100111 detector among N_REQ word-parallel requesters. Each granted word is
// preceded by a one-cycle detector clear, shifted out MSB-first, and its
// detector hits are counted and returned through a valid/ready response.
module seq_detect_scheduler #(
  parameter  int N_REQ  = 4,
  parameter  int WORD_W = 16,
  parameter  int CNT_W  = $clog2(WORD_W + 1),
  localparam int ID_W   = $clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*WORD_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [CNT_W-1:0]          rsp_count,
  input  logic                      rsp_ready,
  output logic                      det_reset,
  output logic                      det_din,
  input  logic                      det_hit,
  output logic                      busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   rr_ptr_reg;
  logic [ID_W-1:0]   id_reg;
  logic [WORD_W-1:0] shreg_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [CNT_W-1:0]  bit_reg;

  logic              any_valid;
  logic [ID_W-1:0]   grant_idx;
  logic              accept;

  // Unpack the flat request bus into one word per requester.
  logic [WORD_W-1:0] req_word [N_REQ];
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign req_word[gi] = req_data[gi*WORD_W +: WORD_W];
  end

  // Round-robin search: first valid index at or after rr_ptr, wrapping.
  // Iterating from the far end lets the nearest candidate overwrite the rest.
  always_comb begin
    any_valid = 1'b0;
    grant_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(rr_ptr_reg) + k) % N_REQ]) begin
        any_valid = 1'b1;
        grant_idx = ID_W'((int'(rr_ptr_reg) + k) % N_REQ);
      end
    end
  end

  // Next-state logic and the combinational one-hot accept.
  always_comb begin
    state_next = state_reg;
    req_ready  = '0;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (any_valid && !reset) begin
          accept               = 1'b1;
          req_ready[grant_idx] = 1'b1;
          state_next           = CLEAR;
        end
      end
      CLEAR: state_next = SHIFT;
      SHIFT: begin
        if (bit_reg == CNT_W'(WORD_W - 1)) begin
          state_next = DRAIN;
        end
      end
      DRAIN: state_next = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register and datapath: capture on accept, shift and count hits.
  // At SHIFT step 0 the detector still reflects its cleared state, so its
  // output is only meaningful from step 1; the final bit's hit lands in DRAIN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= '0;
      id_reg     <= '0;
      shreg_reg  <= '0;
      cnt_reg    <= '0;
      bit_reg    <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            shreg_reg  <= req_word[grant_idx];
            id_reg     <= grant_idx;
            rr_ptr_reg <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
          end
        end
        CLEAR: begin
          cnt_reg <= '0;
          bit_reg <= '0;
        end
        SHIFT: begin
          shreg_reg <= {shreg_reg[WORD_W-2:0], 1'b0};
          bit_reg   <= bit_reg + CNT_W'(1);
          if (det_hit && (bit_reg != '0)) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        DRAIN: begin
          if (det_hit) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are forced quiet while reset is held so nothing escapes an abort.
  assign det_reset = reset | (state_reg == CLEAR);
  assign det_din   = !reset && (state_reg == SHIFT) && shreg_reg[WORD_W-1];
  assign rsp_valid = !reset && (state_reg == RESP);
  assign busy      = !reset && (state_reg != IDLE);
  assign rsp_id    = id_reg;
  assign rsp_count = cnt_reg;

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Bench for seq_detect_scheduler: hosts a behavioural 100111 detector on the
// det_* pins and checks every cycle against a transaction-level model.
module tb_seq_detect_scheduler;
  localparam int N_REQ  = 4;
  localparam int WORD_W = 16;
  localparam int CNT_W  = $clog2(WORD_W + 1);
  localparam int ID_W   = $clog2(N_REQ);
  localparam int LAT    = WORD_W + 3;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*WORD_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    rsp_valid;
  logic [ID_W-1:0]         rsp_id;
  logic [CNT_W-1:0]        rsp_count;
  logic                    rsp_ready;
  logic                    det_reset;
  logic                    det_din;
  logic                    det_hit;
  logic                    busy;

  seq_detect_scheduler #(.N_REQ(N_REQ), .WORD_W(WORD_W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_count(rsp_count), .rsp_ready(rsp_ready), .det_reset(det_reset),
    .det_din(det_din), .det_hit(det_hit), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural Moore detector: high while the last six clocked bits are 100111.
  logic [5:0] det_hist;
  always @(posedge clk) begin
    if (det_reset) det_hist <= '0;
    else           det_hist <= {det_hist[4:0], det_din};
  end
  assign det_hit = (det_hist == 6'b100111);

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction model state.
  bit              m_inflight = 0;
  int              m_age = 0;
  int              m_ptr = 0;
  int              m_id = 0;
  int              m_cnt = 0;
  logic [WORD_W-1:0] m_word = '0;
  int              cyc = 0;
  int              n_rsp = 0;
  int              last_cnt = 0, last_id = 0, last_lat = 0, last_grant = -1;
  int              hs_cyc = 0, acc_cyc = 0;
  int              grants[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Number of (possibly overlapping) 100111 windows inside one word.
  function automatic int ref_count(input logic [WORD_W-1:0] w);
    int c = 0;
    for (int i = 0; i <= WORD_W - 6; i++)
      if (((w >> i) & 16'h3F) == 16'h27) c++;
    return c;
  endfunction

  function automatic int pick(input logic [N_REQ-1:0] v, input int p);
    for (int k = 0; k < N_REQ; k++)
      if (v[(p + k) % N_REQ]) return (p + k) % N_REQ;
    return -1;
  endfunction

  function automatic logic [WORD_W-1:0] rand_word();
    logic [WORD_W-1:0] w;
    int pos;
    w = WORD_W'($urandom);
    if ($urandom_range(0, 1) == 1) begin
      pos = $urandom_range(0, WORD_W - 6);
      w[pos +: 6] = 6'b100111;
    end
    return w;
  endfunction

  // One clock: compare all outputs at the falling edge, then advance the model.
  task automatic cycle();
    logic [N_REQ-1:0] e_ready;
    bit e_rv, e_busy, e_dr, e_din;
    int g;
    @(negedge clk);
    g = pick(req_valid, m_ptr);
    e_ready = '0; e_rv = 0; e_busy = 0; e_dr = reset; e_din = 0;
    if (!reset) begin
      if (!m_inflight && g >= 0) e_ready[g] = 1'b1;
      e_rv   = m_inflight && (m_age >= LAT);
      e_busy = m_inflight;
      e_dr   = m_inflight && (m_age == 1);
      if (m_inflight && m_age >= 2 && m_age <= WORD_W + 1)
        e_din = m_word[WORD_W - 1 - (m_age - 2)];
    end
    chk("req_ready", 32'(req_ready), 32'(e_ready));
    chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("det_reset", 32'(det_reset), 32'(e_dr));
    chk("det_din", 32'(det_din), 32'(e_din));
    if (e_rv) begin
      chk("rsp_id", 32'(rsp_id), 32'(m_id));
      chk("rsp_count", 32'(rsp_count), 32'(m_cnt));
    end
    cyc++;
    if (reset) begin
      m_inflight = 0;
      m_ptr = 0;
    end else if (e_ready != '0) begin
      m_inflight = 1; m_age = 1; m_id = g;
      m_word = req_data[g*WORD_W +: WORD_W];
      m_cnt = ref_count(m_word);
      m_ptr = (g + 1) % N_REQ;
      grants.push_back(g); last_grant = g; acc_cyc = cyc;
    end else if (m_inflight) begin
      if (e_rv && rsp_ready) begin
        m_inflight = 0; n_rsp++;
        last_id = m_id; last_cnt = int'(rsp_count); last_lat = m_age; hs_cyc = cyc;
        $display("rsp id=%0d count=%0d latency=%0d", m_id, rsp_count, m_age);
      end else begin
        m_age++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int guard = 0;
    rsp_ready = 1'b1;
    while (m_inflight && guard < 100) begin cycle(); guard++; end
    chk("drain_timeout", 32'(guard < 100), 32'd1);
  endtask

  task automatic send_word(input int id, input logic [WORD_W-1:0] w);
    int start, guard;
    drain();
    start = n_rsp; guard = 0;
    req_valid = '0; req_valid[id] = 1'b1;
    req_data[id*WORD_W +: WORD_W] = w;
    rsp_ready = 1'b1;
    while (n_rsp == start && guard < 60) begin
      cycle();
      if (m_inflight) begin
        req_valid = '0;
        req_data = {N_REQ{16'hA5A5}};
      end
      guard++;
    end
    chk("send_timeout", 32'(guard < 60), 32'd1);
  endtask

  initial begin
    int guard, start;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    reset = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b1;
    repeat (3) cycle();
    reset = 1'b0;
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_count", 32'(rsp_count), 32'd0);
    chk("rst_det_din", 32'(det_din), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Overlapping matches inside one word.
    send_word(0, 16'h9CF0);
    chk("t1_latency", 32'(last_lat), 32'(LAT));
    chk("t1_id", 32'(last_id), 32'd0);
    chk("t1_count", 32'(last_cnt), 32'd2);

    send_word(1, 16'h0000); chk("t2_zero", 32'(last_cnt), 32'd0);
    send_word(1, 16'hFFFF); chk("t2_ones", 32'(last_cnt), 32'd0);
    send_word(1, 16'h9C00); chk("t2_one_hit", 32'(last_cnt), 32'd1);
    chk("t2_id", 32'(last_id), 32'd1);

    // Pattern split across a word boundary must not match.
    send_word(2, 16'h0009); chk("t3_first", 32'(last_cnt), 32'd0);
    send_word(2, 16'hC000); chk("t3_second", 32'(last_cnt), 32'd0);

    // Round-robin order with every requester valid from reset release.
    drain();
    reset = 1'b1; req_valid = '1;
    for (int i = 0; i < N_REQ; i++) req_data[i*WORD_W +: WORD_W] = rand_word();
    cycle();
    reset = 1'b0; grants.delete(); guard = 0;
    while (grants.size() < 5 && guard < 200) begin cycle(); guard++; end
    chk("rr_timeout", 32'(grants.size() >= 5), 32'd1);
    if (grants.size() >= 5)
      for (int i = 0; i < 5; i++) chk("rr_order", 32'(grants[i]), 32'(exp_order[i]));
    req_valid = '0;
    drain();

    // Stall in RESP with requester 3 waiting.
    req_valid = 4'b1000; req_data[3*WORD_W +: WORD_W] = 16'h9CF0; rsp_ready = 1'b0;
    guard = 0;
    while (!(m_inflight && m_age >= LAT) && guard < 60) begin cycle(); guard++; end
    chk("stall_reach_resp", 32'(guard < 60), 32'd1);
    repeat (10) cycle();
    rsp_ready = 1'b1;
    cycle();
    cycle();
    chk("stall_regrant_gap", 32'(acc_cyc - hs_cyc), 32'd1);
    chk("stall_regrant_id", 32'(last_grant), 32'd3);
    req_valid = '0;
    drain();

    // Reset at SHIFT step 7 aborts the word silently.
    req_valid = 4'b0010; req_data[1*WORD_W +: WORD_W] = rand_word(); guard = 0;
    while (!m_inflight && guard < 20) begin cycle(); guard++; end
    req_valid = '0;
    while (m_age != 9 && guard < 40) begin cycle(); guard++; end
    chk("abort_reach_shift", 32'(guard < 40), 32'd1);
    start = n_rsp;
    reset = 1'b1; cycle(); reset = 1'b0;
    chk("abort_idle", 32'(busy), 32'd0);
    req_valid = '1; req_data[0 +: WORD_W] = 16'h9CF0; guard = 0;
    while (!m_inflight && guard < 20) begin cycle(); guard++; end
    req_valid = '0;
    chk("abort_grant", 32'(last_grant), 32'd0);
    drain();
    chk("abort_rsp_count", 32'(n_rsp - start), 32'd1);
    chk("abort_word_count", 32'(last_cnt), 32'd2);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 1500; c++) begin
      req_valid = N_REQ'($urandom);
      for (int i = 0; i < N_REQ; i++) req_data[i*WORD_W +: WORD_W] = rand_word();
      rsp_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 199) == 0);
      cycle();
    end
    reset = 1'b0; req_valid = '0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
